// File: rtl/shifter_left_seq.sv
// Multi-cycle 32-bit logical left shifter: one shift-amount bit (weights 1,2,4,8,16)
// is resolved per clock, giving a fixed 5-cycle SLL/SLLV latency.
module shifter_left_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] data_out_q, data_out_d;
  logic        done_q, done_d;
  logic [31:0] stage_acc;
  logic        unused_upper;

  // Only the low five bits of the shift amount are meaningful.
  assign unused_upper = ^dataB[31:5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      shamt_q    <= '0;
      k_q        <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      shamt_q    <= shamt_d;
      k_q        <= k_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    shamt_d    = shamt_q;
    k_d        = k_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    stage_acc  = shamt_q[k_q] ? (acc_q << (5'd1 << k_q)) : acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          acc_d   = dataA;
          shamt_d = dataB[4:0];
          k_d     = '0;
        end
      end
      SHIFT: begin
        acc_d = stage_acc;
        k_d   = k_q + 3'd1;
        // Stage 4 publishes the result directly so dataOut and done land together.
        if (k_q == 3'd4) begin
          state_d    = IDLE;
          data_out_d = stage_acc;
          done_d     = 1'b1;
        end
      end
    endcase
  end

  assign dataOut = data_out_q;
  assign done    = done_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_shifter_left_seq.sv
// Self-checking bench for shifter_left_seq: countdown reference model checked every
// cycle, plus directed literal checks and a randomized regression.
module tb_shifter_left_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ops        = 0;

  // Reference model state: cycles left in the current operation and its result.
  int          m_left   = 0;
  logic [31:0] m_result = '0;
  logic [31:0] exp_out  = '0;
  logic        exp_done = 1'b0;
  logic        exp_busy = 1'b0;

  shifter_left_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left   = 0;
      m_result = '0;
      exp_out  = '0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_out  = m_result;
          exp_done = 1'b1;
        end
      end else if (start) begin
        m_result = dataA << dataB[4:0];
        m_left   = 5;
        ops++;
      end
      exp_busy = (m_left > 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_dataOut", dataOut, exp_out);
    chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("model_done", {31'd0, done}, {31'd0, exp_done});
  end

  // Called at a negedge; returns at the negedge where done is seen (or after a bound).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("wait_done_timeout", 32'(n), 32'd0);
  endtask

  // Called at a negedge with the DUT idle (or in its done cycle).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    int n;
    int busy_n;
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n - 1), 32'd5);
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd5);
    chk({nm, "_result"}, dataOut, exp);
  endtask

  initial begin
    int n;
    int e0;
    int dones;
    reset = 1'b1;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    #1;
    chk("reset_dataOut", dataOut, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "shift31");
    @(negedge clk);
    do_op(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "shift0");
    @(negedge clk);
    do_op(32'h1234_5678, 32'hFFFF_FFE4, 32'h2345_6780, "upper_ignored");
    @(negedge clk);

    // Second start while busy must be dropped; inputs changed mid-operation.
    dataA = 32'h0000_FFFF;
    dataB = 32'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dataA = 32'hFFFF_FFFF;
    dataB = 32'd1;
    @(negedge clk);
    start = 1'b0;
    dataA = 32'hA5A5_A5A5;
    dataB = 32'd17;
    wait_done(n);
    chk("busy_drop_result", dataOut, 32'h00FF_FF00);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("busy_drop_single_done", 32'(dones), 32'd0);

    // Reset in the middle of an operation.
    dataA = 32'h0000_0003;
    dataB = 32'd30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_dataOut", dataOut, 32'h0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("midreset_no_done", 32'(dones), 32'd0);
    do_op(32'h0000_0003, 32'd30, 32'hC000_0000, "after_reset");
    @(negedge clk);

    // start held high: accepts every 6 cycles.
    dataA = 32'h0000_0001;
    dataB = 32'd1;
    start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    chk("hold_accept0_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      dataB = 32'(i + 2);
      wait_done(n);
      chk("hold_done_edge", 32'(cyc), 32'(e0 + 6 * i + 5));
      chk("hold_result", dataOut, 32'd1 << (i + 1));
      if (i == 2) start = 1'b0;
      @(negedge clk);
      chk("hold_reaccept_busy", {31'd0, busy}, (i == 2) ? 32'd0 : 32'd1);
    end
    repeat (3) @(negedge clk);

    // Randomized regression with noisy start.
    ops = 0;
    for (int c = 0; c < 20000 && ops < 1100; c++) begin
      start = ($urandom_range(0, 3) != 0);
      dataA = $urandom;
      dataB = $urandom;
      @(negedge clk);
    end
    chk("random_op_count", {31'd0, ops >= 1000}, 32'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
